// File: rtl/cpu_defs.sv
// Constants shared across the 16-bit MIPS datapath: the ALU, the muxes, control and the register file.
package cpu_defs;
  localparam int          DATA_W     = 16;
  localparam int          REG_ADDR_W = 3;
  localparam int          REG_COUNT  = 8;
  localparam logic [2:0]  REG_ZERO   = 3'd0;
endpackage

// File: rtl/reg16_en.sv
// One data register with a synchronous active-high clear and a load enable.
module reg16_en #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/reg_file_8x16.sv
// Eight-entry register file with a hard-wired zero register and two combinational read ports.
// A write in progress is bypassed straight onto any read port addressing the same register.
module reg_file_8x16
  import cpu_defs::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              E,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  WD,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [WIDTH-1:0]  RD1,
  output logic [WIDTH-1:0]  RD2
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic             wr_en;
  logic [NREG-1:1]  load;
  logic [WIDTH-1:0] q [1:NREG-1];
  logic [WIDTH-1:0] rd1_store;
  logic [WIDTH-1:0] rd2_store;
  logic             byp1;
  logic             byp2;

  assign wr_en = E & WE;

  // R0 is never stored, so the decode only produces loads for R1 and up.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      assign load[gi] = wr_en && (WA == ADDR_W'(gi));

      reg16_en #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load[gi]),
        .d     (WD),
        .q     (q[gi])
      );
    end
  endgenerate

  always_comb begin
    rd1_store = '0;
    rd2_store = '0;
    for (int i = 1; i < NREG; i++) begin
      if (RA1 == ADDR_W'(i)) rd1_store = q[i];
      if (RA2 == ADDR_W'(i)) rd2_store = q[i];
    end
  end

  // Bypass is held off during reset so reads show what storage actually holds.
  assign byp1 = ~reset && wr_en && (WA == RA1) && (RA1 != ZERO_ADDR);
  assign byp2 = ~reset && wr_en && (WA == RA2) && (RA2 != ZERO_ADDR);

  assign RD1 = byp1 ? WD : rd1_store;
  assign RD2 = byp2 ? WD : rd2_store;

endmodule

// File: doc/reg_file_8x16.md
# reg_file_8x16

Eight-entry, 16-bit register file for the 16-bit MIPS datapath. It sits directly downstream of the write-back select mux: the mux output drives `WD`, and the two read ports feed the ALU operand muxes. The block provides two combinational read ports, one synchronous write port, a hard-wired zero register, and a same-cycle write-to-read bypass, so the decode stage never sees stale data.

## Interface
Parameters:
- `WIDTH`, 16: data width of each register.
- `ADDR_W`, 3: address width; register count is 2^ADDR_W = 8.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `E`  in  1  write enable gate; a write occurs only when `E`=1 and `WE`=1.
- `WE`  in  1  write request from the control unit (RegWrite).
- `WA`  in  ADDR_W  write address.
- `WD`  in  WIDTH  write data from the write-back mux.
- `RA1`  in  ADDR_W  read address, port 1 (rs).
- `RA2`  in  ADDR_W  read address, port 2 (rt).
- `RD1`  out  WIDTH  read data, port 1.
- `RD2`  out  WIDTH  read data, port 2.

## Operation
- Storage: registers R0..R7, WIDTH bits each. R0 reads as 0 at all times; writes to R0 are discarded, and R0 is not stored.
- Write: on a rising edge with `reset`=0, `E`=1, `WE`=1 and `WA`≠0, R[`WA`] ← `WD`. Otherwise every register holds its value.
- Read: `RDn` is combinational from `RAn`. `RDn`=0 if `RAn`=0.
- Bypass: if `reset`=0, `E`=1, `WE`=1, `WA`=`RAn` and `RAn`≠0, then `RDn`=`WD` (the value being written this cycle). Otherwise `RDn`=R[`RAn`]. Each port bypasses independently; both ports may bypass in the same cycle.
- Reset: a rising edge with `reset`=1 clears R1..R7 to 0. Reset overrides any concurrent write. While `reset`=1, bypass is suppressed and reads return stored contents.
- Simultaneous events:
  - Read and write to the same address: the bypassed value is returned.
  - `RA1`=`RA2`: both ports return identical data.
  - `WE`=1 with `E`=0: no write and no bypass.
- No X propagation: all addresses decode fully (8 of 8), so there are no undefined entries.

## Timing
- Read latency: 0 cycles, purely combinational from `RAn`/`WA`/`WD`/`WE`/`E`/`reset`.
- Write latency: data is visible through storage on the cycle after the write edge, and through bypass in the write cycle itself.
- Reset value of outputs: after the first reset edge, `RD1`=`RD2`=0 for every address until a write occurs.
- Single-cycle CPU use: the write edge at the end of instruction N is read from storage by instruction N+1. The bypass covers the split-phase/pipelined use, where the WB write and the ID read happen in the same cycle.
- No handshake and no stall; the block accepts one write per cycle, every cycle.

## Structure
- Shared constants package/header `cpu_defs`: `DATA_W`=16, `REG_ADDR_W`=3, `REG_COUNT`=8, and `REG_ZERO`=3'd0. These are shared with the ALU, muxes and control.
- Sub-module `reg16_en`: one WIDTH-bit register with synchronous active-high `reset` and load enable. It is instantiated 7 times (R1..R7), with load = `E`&`WE`&(decoded `WA`==i).
- Write-address decode: a 3-to-8 decoder with enable, from the existing decoder block or an equivalent local decode. Output 0 is left unused.
- Read path per port: an 8-to-1 select followed by a 2-to-1 bypass select. This can be built from the existing 2-to-1 mux cells.

## Test plan
- Reset: preload R1..R7 with 16'hFFFF, assert `reset` for 1 edge, then sweep `RA1`/`RA2` over 0..7 → all reads 16'h0000.
- Write/read-back: write R3←16'hA5A5 and R7←16'h1234, then read `RA1`=3, `RA2`=7 next cycle → `RD1`=16'hA5A5, `RD2`=16'h1234.
- R0 protection: `WE`=1, `WA`=0, `WD`=16'hBEEF; read `RA1`=0 in the same cycle and the next → 16'h0000 both times, with no bypass.
- Bypass: R5 holds 16'h0001; in the same cycle set `WA`=5, `WD`=16'h00FF, `WE`=1, `RA1`=`RA2`=5 → both ports 16'h00FF before the edge, and R5=16'h00FF after the edge.
- Enable gating: `E`=0, `WE`=1, `WA`=2, `WD`=16'h5555 with R2=16'h0002 → `RD1`(`RA1`=2)=16'h0002 in that cycle and the next.
- Reset mid-write: `reset`=1 with `WE`=1, `WA`=4, `WD`=16'h7777 on the same edge → R4=0 after the edge, and `RD1`(`RA1`=4)=stored value (no bypass) while `reset`=1.
